// File: rtl/dfm_regbank.sv
// Register bank for a multi-channel frequency meter: byte-wide read port, word-wide write port,
// shadow/active gate times with commit-on-gate-end, sticky done flags and a level interrupt.
module dfm_regbank #(
  parameter int unsigned CH_NUM            = 4,
  parameter logic [31:0] DEFAULT_GATE_TIME = 32'd1000000,
  parameter logic [7:0]  REV               = 8'h20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_rd_en_i,
  input  logic [7:0]            reg_rd_addr_i,
  output logic [7:0]            reg_rd_data_o,
  input  logic                  reg_wr_en_i,
  input  logic [7:0]            reg_wr_addr_i,
  input  logic [31:0]           reg_wr_data_i,
  input  logic [3:0]            reg_wr_be_i,
  input  logic [CH_NUM-1:0]     gate_done_i,
  output logic [32*CH_NUM-1:0]  gate_time_o,
  output logic [CH_NUM-1:0]     gate_load_o,
  output logic [CH_NUM-1:0]     ch_en_o,
  output logic                  irq_o
);

  logic [CH_NUM-1:0] ch_en_q, ch_en_d;
  logic [CH_NUM-1:0] irq_en_q, irq_en_d;
  logic [CH_NUM-1:0] done_q, done_d;
  logic [CH_NUM-1:0] pending_q, pending_d;
  logic [CH_NUM-1:0] load;
  logic [CH_NUM-1:0] gate_load_q;
  logic [31:0]       shadow_q [CH_NUM];
  logic [31:0]       shadow_d [CH_NUM];
  logic [31:0]       active_q [CH_NUM];
  logic [31:0]       active_d [CH_NUM];
  logic              irq_q;
  logic [7:0]        rd_data_q, rd_mux;
  logic [5:0]        wr_word;
  logic [7:0]        shadow_off, active_off;

  assign wr_word = reg_wr_addr_i[7:2];

  always_comb begin
    ch_en_d   = ch_en_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    pending_d = pending_q;
    // A load only ever sees the shadow value held before this edge.
    load      = pending_q & (gate_done_i | ~ch_en_q);
    for (int i = 0; i < int'(CH_NUM); i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = load[i] ? shadow_q[i] : active_q[i];
    end
    pending_d = pending_q & ~load;
    if (reg_wr_en_i) begin
      if (wr_word == 6'd1) begin
        if (reg_wr_be_i[0]) ch_en_d  = reg_wr_data_i[CH_NUM-1:0];
        if (reg_wr_be_i[1]) irq_en_d = reg_wr_data_i[8 +: CH_NUM];
      end
      if (wr_word == 6'd2 && reg_wr_be_i[0]) done_d = done_q & ~reg_wr_data_i[CH_NUM-1:0];
      // Commit set is applied after the load clear so a coincident request survives.
      if (wr_word == 6'd3 && reg_wr_be_i[0]) pending_d = pending_d | reg_wr_data_i[CH_NUM-1:0];
      for (int i = 0; i < int'(CH_NUM); i++) begin
        if (wr_word == 6'(4 + i)) begin
          for (int b = 0; b < 4; b++) begin
            if (reg_wr_be_i[b]) shadow_d[i][8*b +: 8] = reg_wr_data_i[8*b +: 8];
          end
        end
      end
    end
    done_d = done_d | gate_done_i;
  end

  assign shadow_off = reg_rd_addr_i - 8'h10;
  assign active_off = reg_rd_addr_i - 8'h30;

  always_comb begin
    rd_mux = 8'h00;
    unique case (reg_rd_addr_i)
      8'h00:   rd_mux = 8'hDF;
      8'h01:   rd_mux = REV;
      8'h02:   rd_mux = 8'(CH_NUM);
      8'h04:   rd_mux = 8'(ch_en_q);
      8'h05:   rd_mux = 8'(irq_en_q);
      8'h08:   rd_mux = 8'(done_q);
      8'h0C:   rd_mux = 8'(pending_q);
      default: rd_mux = 8'h00;
    endcase
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (shadow_off < 8'd32 && shadow_off[4:2] == 3'(i)) begin
        rd_mux = shadow_q[i][{shadow_off[1:0], 3'b000} +: 8];
      end
      if (active_off < 8'd32 && active_off[4:2] == 3'(i)) begin
        rd_mux = active_q[i][{active_off[1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_en_q     <= '0;
      irq_en_q    <= '0;
      done_q      <= '0;
      pending_q   <= '0;
      gate_load_q <= '0;
      irq_q       <= 1'b0;
      rd_data_q   <= 8'h00;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        shadow_q[i] <= DEFAULT_GATE_TIME;
        active_q[i] <= DEFAULT_GATE_TIME;
      end
    end else begin
      ch_en_q     <= ch_en_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      pending_q   <= pending_d;
      gate_load_q <= load;
      irq_q       <= |(done_q & irq_en_q);
      if (reg_rd_en_i) rd_data_q <= rd_mux;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_gate_time
    assign gate_time_o[32*g +: 32] = active_q[g];
  end

  assign reg_rd_data_o = rd_data_q;
  assign gate_load_o   = gate_load_q;
  assign ch_en_o       = ch_en_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_dfm_regbank.sv
// Directed bench for dfm_regbank: a table of register reads after reset, then hand-written
// sequences for commit/load, done/irq, byte enables, commit-vs-load and reset priority.
module tb_dfm_regbank;

  localparam int unsigned CH  = 4;
  localparam logic [31:0] DGT = 32'd1000000;  // 0x000F4240

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_en = 1'b0;
  logic [7:0]        rd_addr = 8'h00;
  logic [7:0]        rd_data;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_addr = 8'h00;
  logic [31:0]       wr_data = 32'h0;
  logic [3:0]        wr_be = 4'h0;
  logic [CH-1:0]     gate_done = '0;
  logic [32*CH-1:0]  gate_time;
  logic [CH-1:0]     gate_load;
  logic [CH-1:0]     ch_en;
  logic              irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dfm_regbank #(
    .CH_NUM           (CH),
    .DEFAULT_GATE_TIME(DGT),
    .REV              (8'h20)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reg_rd_en_i  (rd_en),
    .reg_rd_addr_i(rd_addr),
    .reg_rd_data_o(rd_data),
    .reg_wr_en_i  (wr_en),
    .reg_wr_addr_i(wr_addr),
    .reg_wr_data_i(wr_data),
    .reg_wr_be_i  (wr_be),
    .gate_done_i  (gate_done),
    .gate_time_o  (gate_time),
    .gate_load_o  (gate_load),
    .ch_en_o      (ch_en),
    .irq_o        (irq)
  );

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    d       = rd_data;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    chk(nm, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    tick();
    wr_en   = 1'b0;
    wr_be   = 4'h0;
  endtask

  function automatic logic [31:0] gt(input int ch);
    return gate_time[32*ch +: 32];
  endfunction

  initial begin
    vecs[0]  = '{"id",          8'h00, 8'hDF};
    vecs[1]  = '{"rev",         8'h01, 8'h20};
    vecs[2]  = '{"ch_num",      8'h02, 8'h04};
    vecs[3]  = '{"active0_b0",  8'h30, 8'h40};
    vecs[4]  = '{"active0_b1",  8'h31, 8'h42};
    vecs[5]  = '{"active0_b2",  8'h32, 8'h0F};
    vecs[6]  = '{"active0_b3",  8'h33, 8'h00};
    vecs[7]  = '{"shadow3_b0",  8'h1C, 8'h40};
    vecs[8]  = '{"ctrl",        8'h04, 8'h00};
    vecs[9]  = '{"irq_en",      8'h05, 8'h00};
    vecs[10] = '{"done",        8'h08, 8'h00};
    vecs[11] = '{"pending",     8'h0C, 8'h00};
    vecs[12] = '{"unmapped03",  8'h03, 8'h00};
    vecs[13] = '{"shadow4",     8'h20, 8'h00};
    vecs[14] = '{"unmappedFF",  8'hFF, 8'h00};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
    chk("rst_gate_load", {28'h0, gate_load}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_ch_en", {28'h0, ch_en}, 32'h0);
    chk("rst_gate_time3", gt(3), DGT);

    for (int i = 0; i < 15; i++) rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);

    // Read data holds while the strobe is low
    rd_chk("rd_id_again", 8'h00, 8'hDF);
    rd_addr = 8'h01;
    tick();
    chk("rd_hold", {24'h0, rd_data}, 32'h0000_00DF);

    // Disabled channel loads on the edge after commit
    wr(8'h14, 32'h1234_5678, 4'hF);
    wr(8'h0C, 32'h2, 4'h1);
    chk("commit_no_load_yet", {28'h0, gate_load}, 32'h0);
    chk("commit_active1_old", gt(1), DGT);
    tick();
    chk("load1_pulse", {28'h0, gate_load}, 32'h2);
    chk("load1_active", gt(1), 32'h1234_5678);
    tick();
    chk("load1_pulse_end", {28'h0, gate_load}, 32'h0);
    rd_chk("load1_pending", 8'h0C, 8'h00);
    rd_chk("load1_rd_b3", 8'h37, 8'h12);

    // Enabled channel waits for gate end
    wr(8'h04, 32'h1, 4'h1);
    wr(8'h10, 32'hCAFE_BABE, 4'hF);
    wr(8'h0C, 32'h1, 4'h1);
    tick();
    tick();
    chk("ch0_wait_active", gt(0), DGT);
    chk("ch0_wait_load", {28'h0, gate_load}, 32'h0);
    gate_done = 4'h1;
    tick();
    gate_done = 4'h0;
    chk("ch0_load_pulse", {28'h0, gate_load}, 32'h1);
    chk("ch0_active", gt(0), 32'hCAFE_BABE);
    rd_chk("ch0_done", 8'h08, 8'h01);
    wr(8'h08, 32'h1, 4'h1);
    rd_chk("ch0_done_clr", 8'h08, 8'h00);

    // Set beats coincident W1C; irq one cycle behind DONE
    wr(8'h04, 32'h0000_0400, 4'b0010);
    chk("irq_en_ch_en_kept", {28'h0, ch_en}, 32'h1);
    wr_en = 1'b1; wr_addr = 8'h08; wr_data = 32'h4; wr_be = 4'h1;
    gate_done = 4'h4;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; gate_done = 4'h0;
    chk("irq_lag", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd_chk("done2_kept", 8'h08, 8'h04);
    wr(8'h08, 32'h4, 4'h1);
    tick();
    chk("irq_clr", {31'h0, irq}, 32'h0);
    rd_chk("done2_clr", 8'h08, 8'h00);

    // Byte enables, read-only and out-of-range channels
    wr(8'h10, 32'h1122_3344, 4'b0010);
    rd_chk("be_b0", 8'h10, 8'hBE);
    rd_chk("be_b1", 8'h11, 8'h33);
    rd_chk("be_b2", 8'h12, 8'hFE);
    rd_chk("be_b3", 8'h13, 8'hCA);
    wr(8'h30, 32'h0, 4'hF);
    chk("ro_active0", gt(0), 32'hCAFE_BABE);
    rd_chk("ro_rd_b0", 8'h30, 8'hBE);
    rd_chk("ch4_active", 8'h40, 8'h00);
    rd_chk("ch7_active", 8'h4F, 8'h00);
    wr(8'h04, 32'hFF, 4'h1);
    chk("ch_en_mask", {28'h0, ch_en}, 32'hF);
    rd_chk("ctrl_mask", 8'h04, 8'h0F);

    // Commit coinciding with a load keeps the new request pending
    wr(8'h1C, 32'hA5A5_A5A5, 4'hF);
    wr(8'h0C, 32'h8, 4'h1);
    tick();
    chk("ch3_wait", gt(3), DGT);
    wr_en = 1'b1; wr_addr = 8'h0C; wr_data = 32'h8; wr_be = 4'h1;
    gate_done = 4'h8;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; gate_done = 4'h0;
    chk("ch3_load_pulse", {28'h0, gate_load}, 32'h8);
    chk("ch3_active", gt(3), 32'hA5A5_A5A5);
    rd_chk("ch3_pending_kept", 8'h0C, 8'h08);

    // Reset beats a coincident commit and gate end
    rd_chk("pre_rst_id", 8'h00, 8'hDF);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 8'h0C; wr_data = 32'hF; wr_be = 4'h1;
    gate_done = 4'hF;
    tick();
    rst = 1'b0; wr_en = 1'b0; wr_be = 4'h0; gate_done = 4'h0;
    chk("rst2_gate_load", {28'h0, gate_load}, 32'h0);
    chk("rst2_rd_data", {24'h0, rd_data}, 32'h0);
    chk("rst2_ch_en", {28'h0, ch_en}, 32'h0);
    chk("rst2_active0", gt(0), DGT);
    chk("rst2_active3", gt(3), DGT);
    tick();
    chk("rst2_no_load", {28'h0, gate_load}, 32'h0);
    chk("rst2_irq", {31'h0, irq}, 32'h0);
    rd_chk("rst2_pending", 8'h0C, 8'h00);
    rd_chk("rst2_done", 8'h08, 8'h00);
    rd_chk("rst2_irq_en", 8'h05, 8'h00);
    rd_chk("rst2_shadow0", 8'h10, 8'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
